// File: rtl/cpu_defs.sv
// cpu_defs: opcodes, IR field positions and sequencer state/class encodings.
package cpu_defs;
  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_LDI  = 5'b00001;
  localparam logic [4:0] OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_SHR  = 5'b00101;
  localparam logic [4:0] OP_SHRA = 5'b00110;
  localparam logic [4:0] OP_SHL  = 5'b00111;
  localparam logic [4:0] OP_ROR  = 5'b01000;
  localparam logic [4:0] OP_ROL  = 5'b01001;
  localparam logic [4:0] OP_AND  = 5'b01010;
  localparam logic [4:0] OP_OR   = 5'b01011;
  localparam logic [4:0] OP_ADDI = 5'b01100;
  localparam logic [4:0] OP_ANDI = 5'b01101;
  localparam logic [4:0] OP_ORI  = 5'b01110;
  localparam logic [4:0] OP_DIV  = 5'b01111;
  localparam logic [4:0] OP_MUL  = 5'b10000;
  localparam logic [4:0] OP_NEG  = 5'b10001;
  localparam logic [4:0] OP_NOT  = 5'b10010;
  localparam logic [4:0] OP_NOP  = 5'b11010;
  localparam logic [4:0] OP_HALT = 5'b11011;
  localparam int OP_LSB = 27;
  localparam int RA_LSB = 23;
  localparam int RB_LSB = 19;
  localparam int RC_LSB = 15;
  typedef enum logic [3:0] {T0, T1, T2, T3, T4, T5, T6, T7, HALT} state_t;
  typedef enum logic [3:0] {C_R, C_MD, C_UN, C_IMM, C_LD, C_ST, C_NOP, C_HALT, C_ILL} cls_t;
  // ldi shares the immediate flow; only its base-address slot differs
  function automatic cls_t classify(input logic [4:0] op);
    return (op >= OP_ADD && op <= OP_OR) ? C_R :
           (op == OP_MUL || op == OP_DIV) ? C_MD :
           (op == OP_NEG || op == OP_NOT) ? C_UN :
           (op == OP_LDI || (op >= OP_ADDI && op <= OP_ORI)) ? C_IMM :
           op == OP_LD ? C_LD : op == OP_ST ? C_ST : op == OP_NOP ? C_NOP :
           op == OP_HALT ? C_HALT : C_ILL;
  endfunction
endpackage

// File: rtl/reg_select_decoder.sv
// reg_select_decoder: 4-bit register field to one-hot select, R0 becomes BAout in base slots.
module reg_select_decoder #(
  parameter int REGS = 16
) (
  input  logic [3:0]      field,
  input  logic            en,
  input  logic            ba,
  output logic [REGS-1:0] sel,
  output logic            ba_out
);
  assign ba_out = en && ba && field == 4'd0;
  assign sel = (en && !ba_out) ? REGS'(1) << field : '0;
endmodule

// File: rtl/control_sequencer.sv
// control_sequencer: hardwired fetch/decode/execute control unit driving datapath strobes.
module control_sequencer
  import cpu_defs::*;
#(
  parameter int OPW  = 5,
  parameter int REGS = 16
) (
  input  logic            clock,
  input  logic            clear,
  input  logic [31:0]     ir,
  input  logic            mem_ready,
  output logic [REGS-1:0] Rin,
  output logic [REGS-1:0] Rout,
  output logic            PCout, incPC, MARin, MDRin, MDRout, IRin, Yin, Zin,
  output logic            ZLowOut, ZHighOut, HIin, LOin, Cout, BAout, read, write,
  output logic [OPW-1:0]  alu_op,
  output logic            run,
  output logic            illegal
);
  state_t state, nxt;
  cls_t cls;
  logic [4:0] op, imm_alu;
  logic [3:0] ra, rb, rc, rout_f;
  logic rout_en, rout_ba, rin_en, unused_rin_ba, unused_ir;
  assign op = ir[OP_LSB +: 5];
  assign ra = ir[RA_LSB +: 4];
  assign rb = ir[RB_LSB +: 4];
  assign rc = ir[RC_LSB +: 4];
  assign unused_ir = ^ir[RC_LSB-1:0];
  assign cls = classify(op);
  assign imm_alu = op == OP_ANDI ? OP_AND : op == OP_ORI ? OP_OR : OP_ADD;
  assign run = !clear && state != HALT;
  always_ff @(posedge clock) state <= clear ? T0 : nxt;
  always_comb begin
    nxt = state;
    {PCout, incPC, MARin, MDRin, MDRout, IRin, Yin, Zin} = '0;
    {ZLowOut, ZHighOut, HIin, LOin, Cout, read, write, illegal} = '0;
    rout_en = 1'b0;
    rout_f = rb;
    rout_ba = 1'b0;
    rin_en = 1'b0;
    alu_op = '0;
    if (!clear) case (state)
      T0: begin
        {PCout, MARin, incPC} = '1;
        nxt = T1;
      end
      T1: begin
        {read, MDRin} = '1;
        nxt = mem_ready ? T2 : T1;
      end
      T2: begin
        {MDRout, IRin} = '1;
        nxt = T3;
      end
      T3: begin
        rout_en = cls inside {C_R, C_MD, C_UN, C_IMM, C_LD, C_ST};
        rout_f = cls == C_MD ? ra : rb;
        rout_ba = cls inside {C_LD, C_ST} || op == OP_LDI;
        Yin = rout_en && cls != C_UN;
        Zin = cls == C_UN;
        alu_op = cls == C_UN ? OPW'(op) : '0;
        illegal = cls == C_ILL;
        nxt = cls == C_HALT ? HALT : cls inside {C_NOP, C_ILL} ? T0 : T4;
      end
      T4: begin
        rout_en = cls inside {C_R, C_MD};
        rout_f = cls == C_R ? rc : rb;
        Cout = cls inside {C_IMM, C_LD, C_ST};
        Zin = cls != C_UN;
        ZLowOut = cls == C_UN;
        rin_en = cls == C_UN;
        alu_op = cls == C_UN ? '0 : Cout ? OPW'(imm_alu) : OPW'(op);
        nxt = cls == C_UN ? T0 : T5;
      end
      T5: begin
        ZLowOut = 1'b1;
        rin_en = cls inside {C_R, C_IMM};
        LOin = cls == C_MD;
        MARin = cls inside {C_LD, C_ST};
        nxt = rin_en ? T0 : T6;
      end
      T6: begin
        {ZHighOut, HIin} = {2{cls == C_MD}};
        read = cls == C_LD;
        rout_en = cls == C_ST;
        rout_f = ra;
        MDRin = cls inside {C_LD, C_ST};
        nxt = cls == C_MD ? T0 : (cls == C_LD && !mem_ready) ? T6 : T7;
      end
      T7: begin
        MDRout = cls == C_LD;
        rin_en = cls == C_LD;
        write = cls == C_ST;
        nxt = (cls == C_ST && !mem_ready) ? T7 : T0;
      end
      HALT: nxt = HALT;
      default: nxt = T0;
    endcase
  end
  reg_select_decoder #(.REGS(REGS)) u_rout (
    .field(rout_f), .en(rout_en), .ba(rout_ba), .sel(Rout), .ba_out(BAout)
  );
  reg_select_decoder #(.REGS(REGS)) u_rin (
    .field(ra), .en(rin_en), .ba(1'b0), .sel(Rin), .ba_out(unused_rin_ba)
  );
endmodule

// File: tb/tb_control_sequencer.sv
// tb_control_sequencer: random and directed instructions checked cycle by cycle against a step-list model.
module tb_control_sequencer;
  typedef struct packed {
    logic [15:0] rin, rout;
    logic pc_out, inc_pc, mar_in, mdr_in, mdr_out, ir_in, y_in, z_in;
    logic zlo, zhi, hi_in, lo_in, c_out, ba_out, rd, wr;
    logic [4:0] alu;
    logic run, ill;
  } obs_t;
  logic clk = 1'b0, clear = 1'b1, mem_ready = 1'b0;
  logic [31:0] ir = '0;
  logic [15:0] Rin, Rout;
  logic PCout, incPC, MARin, MDRin, MDRout, IRin, Yin, Zin;
  logic ZLowOut, ZHighOut, HIin, LOin, Cout, BAout, read, write, run, illegal;
  logic [4:0] alu_op;
  int checks = 0, errors = 0;
  obs_t exp_q[$];
  bit wait_q[$];
  always #5 clk = ~clk;
  control_sequencer dut (
    .clock(clk), .clear(clear), .ir(ir), .mem_ready(mem_ready), .Rin(Rin), .Rout(Rout),
    .PCout(PCout), .incPC(incPC), .MARin(MARin), .MDRin(MDRin), .MDRout(MDRout), .IRin(IRin),
    .Yin(Yin), .Zin(Zin), .ZLowOut(ZLowOut), .ZHighOut(ZHighOut), .HIin(HIin), .LOin(LOin),
    .Cout(Cout), .BAout(BAout), .read(read), .write(write), .alu_op(alu_op), .run(run),
    .illegal(illegal)
  );
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  function automatic obs_t observe();
    obs_t o;
    o = '{rin: Rin, rout: Rout, pc_out: PCout, inc_pc: incPC, mar_in: MARin, mdr_in: MDRin,
          mdr_out: MDRout, ir_in: IRin, y_in: Yin, z_in: Zin, zlo: ZLowOut, zhi: ZHighOut,
          hi_in: HIin, lo_in: LOin, c_out: Cout, ba_out: BAout, rd: read, wr: write,
          alu: alu_op, run: run, ill: illegal};
    return o;
  endfunction
  function automatic logic [15:0] oh(input logic [3:0] r);
    return 16'(1) << r;
  endfunction
  function automatic void add(input obs_t o, input bit w);
    exp_q.push_back(o);
    wait_q.push_back(w);
  endfunction
  // One expected output word per state; w marks states that wait on mem_ready
  function automatic void build(input logic [31:0] ins);
    logic [4:0] op;
    logic [3:0] ra, rb, rc;
    obs_t z, s;
    op = ins[31:27]; ra = ins[26:23]; rb = ins[22:19]; rc = ins[18:15];
    z = '0; z.run = 1'b1;
    exp_q.delete(); wait_q.delete();
    s = z; s.pc_out = 1; s.mar_in = 1; s.inc_pc = 1; add(s, 0);
    s = z; s.rd = 1; s.mdr_in = 1; add(s, 1);
    s = z; s.mdr_out = 1; s.ir_in = 1; add(s, 0);
    if (op >= 3 && op <= 11) begin
      s = z; s.rout = oh(rb); s.y_in = 1; add(s, 0);
      s = z; s.rout = oh(rc); s.z_in = 1; s.alu = op; add(s, 0);
      s = z; s.zlo = 1; s.rin = oh(ra); add(s, 0);
    end else if (op == 15 || op == 16) begin
      s = z; s.rout = oh(ra); s.y_in = 1; add(s, 0);
      s = z; s.rout = oh(rb); s.z_in = 1; s.alu = op; add(s, 0);
      s = z; s.zlo = 1; s.lo_in = 1; add(s, 0);
      s = z; s.zhi = 1; s.hi_in = 1; add(s, 0);
    end else if (op == 17 || op == 18) begin
      s = z; s.rout = oh(rb); s.z_in = 1; s.alu = op; add(s, 0);
      s = z; s.zlo = 1; s.rin = oh(ra); add(s, 0);
    end else if (op <= 2 || (op >= 12 && op <= 14)) begin
      s = z; s.y_in = 1;
      if (op <= 2 && rb == 0) s.ba_out = 1; else s.rout = oh(rb);
      add(s, 0);
      s = z; s.c_out = 1; s.z_in = 1; s.alu = op == 13 ? 5'd10 : op == 14 ? 5'd11 : 5'd3; add(s, 0);
      s = z; s.zlo = 1;
      if (op == 0 || op == 2) s.mar_in = 1; else s.rin = oh(ra);
      add(s, 0);
      if (op == 0) begin
        s = z; s.rd = 1; s.mdr_in = 1; add(s, 1);
        s = z; s.mdr_out = 1; s.rin = oh(ra); add(s, 0);
      end else if (op == 2) begin
        s = z; s.rout = oh(ra); s.mdr_in = 1; add(s, 0);
        s = z; s.wr = 1; add(s, 1);
      end
    end else if (op == 26 || op == 27) add(z, 0);
    else begin
      s = z; s.ill = 1; add(s, 0);
    end
  endfunction
  // Entered in the low phase with the DUT in T0; returns in the low phase with the DUT in its next state
  task automatic run_instr(input logic [31:0] ins, input int lows, input bit rnd, input bit cut);
    int i = 0, waits = 0;
    bit mr;
    ir = ins;
    build(ins);
    while (i < exp_q.size()) begin
      #1 check($sformatf("ir=%h step%0d", ins, i), 64'(observe()), 64'(exp_q[i]));
      if (cut && i == exp_q.size() - 1) begin
        clear = 1'b1; mem_ready = 1'b0;
        #1 check("clear_now", 64'(observe()), 64'(0));
        @(negedge clk);
        #1 check("clear_t0", 64'(observe()), 64'(0));
        clear = 1'b0;
        return;
      end
      if (wait_q[i] && lows > 0) begin
        mr = 1'b0; lows--;
      end else mr = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (wait_q[i] && !mr && ++waits > 8) mr = 1'b1;
      mem_ready = mr;
      if (!wait_q[i] || mr) begin
        i++; waits = 0;
      end
      @(negedge clk);
    end
  endtask
  initial begin
    logic [4:0] opc;
    logic [3:0] rb;
    repeat (3) begin
      @(negedge clk);
      #1 check("reset", 64'(observe()), 64'(0));
    end
    @(negedge clk);
    clear = 1'b0;
    run_instr(32'h23A18000, 0, 0, 0);
    run_instr(32'hD0000000, 3, 0, 0);
    run_instr(32'h81280000, 0, 1, 0);
    run_instr(32'h00800010, 2, 1, 0);
    run_instr(32'h11900004, 0, 1, 1);
    run_instr(32'h11900004, 1, 1, 0);
    for (int n = 0; n < 200; n++) begin
      opc = 5'($urandom);
      if (opc == 5'd27) opc = 5'd26;
      rb = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom);
      run_instr({opc, 4'($urandom), rb, 4'($urandom), 15'($urandom)}, 0, 1, 0);
    end
    run_instr(32'hD8000000, 0, 1, 0);
    for (int n = 0; n < 20; n++) begin
      #1 check("halted", 64'(observe()), 64'(0));
      mem_ready = 1'($urandom);
      @(negedge clk);
    end
    clear = 1'b1;
    #1 check("halt_clear", 64'(observe()), 64'(0));
    @(negedge clk);
    clear = 1'b0;
    run_instr(32'h23A18000, 0, 1, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
